// File: rtl/gb_pkg.sv
// Shared Game Boy SoC definitions: DMA state encoding, register address and echo-RAM mapping.
package gb_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_START = 2'd1,
        DMA_READ  = 2'd2,
        DMA_WRITE = 2'd3
    } dma_state_t;

    localparam int unsigned OAM_DMA_LEN  = 160;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [7:0]  ECHO_BASE    = 8'hE0;
    localparam logic [7:0]  ECHO_OFFSET  = 8'h20;

    // Pages E0-FF alias C0-DF so a transfer can never read OAM or IO space.
    function automatic logic [7:0] dma_src_hi(input logic [7:0] page);
        return (page >= ECHO_BASE) ? page - ECHO_OFFSET : page;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies LEN bytes from page XX00 into OAM, one byte per M-cycle.
// Optional OAM_DMA_READBACK_EN makes reg_rdata return the last written page.
module oam_dma
    import gb_pkg::*;
#(
    parameter int unsigned LEN         = OAM_DMA_LEN,
    parameter int unsigned START_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_tick,
    input  logic        reg_wr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic [15:0] src_addr,
    output logic        src_rd,
    input  logic [7:0]  src_data,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        busy
);

    localparam logic [7:0] LAST_IDX   = 8'(LEN - 1);
    localparam logic [7:0] DLY_INIT   = 8'(START_DELAY);
    localparam dma_state_t LOAD_STATE = (START_DELAY == 0) ? DMA_READ : DMA_START;

    dma_state_t  r_state, w_state;
    logic [7:0]  r_idx, w_idx;
    logic [7:0]  r_dly, w_dly;
    logic [7:0]  r_page, w_page;
    logic [15:0] r_src_addr, w_src_addr;
    logic        r_src_rd, w_src_rd;
    logic [7:0]  r_oam_addr, w_oam_addr;
    logic        r_oam_we, w_oam_we;
    logic        r_busy, w_busy;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= DMA_IDLE;
            r_idx      <= 8'h00;
            r_dly      <= 8'h00;
            r_page     <= 8'hFF;
            r_src_addr <= 16'h0000;
            r_src_rd   <= 1'b0;
            r_oam_addr <= 8'h00;
            r_oam_we   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_dly      <= w_dly;
            r_page     <= w_page;
            r_src_addr <= w_src_addr;
            r_src_rd   <= w_src_rd;
            r_oam_addr <= w_oam_addr;
            r_oam_we   <= w_oam_we;
            r_busy     <= w_busy;
        end
    end

    // Next state; the WRITE cycle coincides with the visible src_rd, so oam_we lands on the data cycle.
    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_dly      = r_dly;
        w_page     = r_page;
        w_src_addr = r_src_addr;
        w_src_rd   = 1'b0;
        w_oam_addr = r_oam_addr;
        w_oam_we   = 1'b0;

        if (reg_wr) begin
            w_page  = reg_wdata;
            w_idx   = 8'h00;
            w_dly   = DLY_INIT;
            w_state = LOAD_STATE;
        end else begin
            case (r_state)
                DMA_START: begin
                    if (m_tick) begin
                        w_dly = r_dly - 8'd1;
                        if (r_dly <= 8'd1) begin
                            w_state = DMA_READ;
                        end
                    end
                end
                DMA_READ: begin
                    if (m_tick) begin
                        w_src_addr = {dma_src_hi(r_page), r_idx};
                        w_src_rd   = 1'b1;
                        w_state    = DMA_WRITE;
                    end
                end
                DMA_WRITE: begin
                    w_oam_we   = 1'b1;
                    w_oam_addr = r_idx;
                    if (r_idx == LAST_IDX) begin
                        w_state = DMA_IDLE;
                    end else begin
                        w_idx   = r_idx + 8'd1;
                        w_state = DMA_READ;
                    end
                end
                default: begin
                end
            endcase
        end

        // Held through the final OAM write so busy drops the clk after it.
        w_busy = (w_state != DMA_IDLE) || w_oam_we;
    end

    assign src_addr  = r_src_addr;
    assign src_rd    = r_src_rd;
    assign oam_addr  = r_oam_addr;
    assign oam_we    = r_oam_we;
    assign busy      = r_busy;
    assign oam_wdata = r_oam_we ? src_data : 8'h00;

`ifdef OAM_DMA_READBACK_EN
    assign reg_rdata = r_page;
`else
    assign reg_rdata = 8'hFF;
`endif

endmodule
